// File: rtl/seq_chunk_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder
// Purpose  : Sequential (bit-serial-by-chunk) adder/subtractor. One CHUNK-bit
//            slice of the operands is added per clock; the carry ripples
//            between slices through a register. Takes NCH = WIDTH/CHUNK
//            cycles per operation, plus a handshake cycle in and out.
// Ports    : clk, rst        - clock (rising edge), async active-high reset
//            in_valid/ready  - operation handshake (a, b, cin, sub)
//            a, b            - WIDTH-bit operands
//            cin             - carry-in, add mode only
//            sub             - 0: a+b+cin, 1: a-b
//            out_valid/ready - result handshake (sum, carry, overflow)
//            sum             - WIDTH-bit result
//            carry           - carry out of MSB (subtract: 1 = no borrow)
//            overflow        - two's-complement signed overflow
// Note     : WIDTH must be an integer multiple of CHUNK, CHUNK >= 1.
// Revision : 1.0 - initial release
// ============================================================================
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // effective B (already inverted for subtract)
  logic             c_q, c_d;     // carry into the current slice
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_co;
  logic             msb_ci;

  assign slice_a = a_q[idx_q*CHUNK +: CHUNK];
  assign slice_b = b_q[idx_q*CHUNK +: CHUNK];
  assign {slice_co, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, c_q};

  // Carry into the slice MSB recovered from the MSB sum bit; works for any
  // CHUNK including 1, where it degenerates to the slice carry-in.
  assign msb_ci = slice_s[CHUNK-1] ^ slice_a[CHUNK-1] ^ slice_b[CHUNK-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = slice_s;
        c_d = slice_co;
        if (idx_q == LAST_IDX) begin
          carry_d = slice_co;
          ovf_d   = msb_ci ^ slice_co;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // in_ready is gated by rst so it drops immediately on reset assertion.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_chunk_adder
// Purpose  : Self-checking bench. Three instances (CHUNK = 4, 16, 1) share
//            the same stimulus; each result is compared against a signed /
//            unsigned integer reference model, along with latency, hold in
//            DONE, handshake and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        cin;
  logic        sub;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;

  logic        rdy [NI];
  logic        ov  [NI];
  logic        cy  [NI];
  logic        of  [NI];
  logic [15:0] sm  [NI];

  int lat_exp [NI];
  int checks = 0;
  int errors = 0;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[0]), .out_ready(out_ready),
    .sum(sm[0]), .carry(cy[0]), .overflow(of[0])
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[1]), .out_ready(out_ready),
    .sum(sm[1]), .carry(cy[1]), .overflow(of[1])
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[2]), .out_ready(out_ready),
    .sum(sm[2]), .carry(cy[2]), .overflow(of[2])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {overflow, carry, sum} from integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    int          sx, sy, res;
    logic [16:0] u;
    logic        c;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      res = sx - sy;
      u   = {1'b0, x} - {1'b0, y};
      c   = (x >= y);
    end else begin
      res = sx + sy + int'(ci);
      u   = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      c   = u[16];
    end
    return {(res > 32767) || (res < -32768), c, u[15:0]};
  endfunction

  // Run one operation on all instances; hold = extra DONE cycles with
  // out_ready low. Called at a point away from the clock edge.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input logic s, input int hold, input string tag);
    logic [17:0] e;
    logic [17:0] held [NI];
    int          lat  [NI];
    bit          seen [NI];
    e = model(x, y, ci, s);
    a = x; b = y; cin = ci; sub = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("%s_rdy%0d", tag, i), rdy[i], 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      seen[i] = 1'b0;
      lat[i]  = -1;
      held[i] = '0;
    end
    for (int k = 1; k <= 16 + hold; k++) begin
      // Garbage on the inputs must be ignored in RUN and DONE.
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        check($sformatf("%s_busy_rdy%0d", tag, i), rdy[i], 0);
        if (seen[i]) begin
          check($sformatf("%s_hold_ov%0d", tag, i), ov[i], 1);
          check($sformatf("%s_hold_res%0d", tag, i), {of[i], cy[i], sm[i]}, held[i]);
        end else if (ov[i]) begin
          seen[i] = 1'b1;
          lat[i]  = k;
          held[i] = {of[i], cy[i], sm[i]};
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_lat%0d", tag, i), lat[i], lat_exp[i]);
      check($sformatf("%s_res%0d", tag, i), {of[i], cy[i], sm[i]}, e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_idle_ov%0d", tag, i), ov[i], 0);
      check($sformatf("%s_idle_rdy%0d", tag, i), rdy[i], 1);
      check($sformatf("%s_idle_res%0d", tag, i), {of[i], cy[i], sm[i]}, e);
    end
  endtask

  task automatic check_const(input string tag, input logic [15:0] s_e,
                             input logic c_e, input logic o_e);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_sum%0d", tag, i), sm[i], s_e);
      check($sformatf("%s_carry%0d", tag, i), cy[i], c_e);
      check($sformatf("%s_ovf%0d", tag, i), of[i], o_e);
    end
  endtask

  initial begin
    lat_exp[0] = 4;
    lat_exp[1] = 16;
    lat_exp[2] = 1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_rdy%0d", i), rdy[i], 0);
      check($sformatf("rst_ov%0d", i), ov[i], 0);
    end
    check_const("rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_wrap");
    check_const("add_wrap", 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "add_ovf");
    check_const("add_ovf", 16'h8000, 1'b0, 1'b1);
    do_op(16'h1234, 16'h1111, 1'b1, 1'b0, 0, "add_cin");
    check_const("add_cin", 16'h2346, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 3, "sub_bp");
    check_const("sub_bp", 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
    check_const("sub_ovf", 16'h7FFF, 1'b1, 1'b1);

    // Reset mid-operation: CHUNK=4 and CHUNK=1 are in RUN, CHUNK=16 in DONE.
    a = 16'h1357; b = 16'h2468; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("midrst_ov%0d", i), ov[i], 0);
      check($sformatf("midrst_rdy%0d", i), rdy[i], 0);
    end
    check_const("midrst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, "post_rst");
    check_const("post_rst", 16'h0100, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 2), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
